// File: rtl/ram_pkg.sv
// Shared response codes and address decode for the AXI-lite data RAM.
package ram_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef struct packed {
    logic [1:0]  resp;
    logic [63:0] idx;
  } dec_t;

  // Addresses below base underflow to a huge offset, but the explicit compare catches them first.
  function automatic dec_t decode(input logic [63:0] addr, input logic [63:0] base,
                                  input logic [63:0] depth, input int unsigned off_bits);
    dec_t        d;
    logic [63:0] off;
    off   = addr - base;
    d.idx = off >> off_bits;
    if (addr < base || d.idx >= depth)                            d.resp = RESP_DECERR;
    else if ((off & ((64'd1 << off_bits) - 64'd1)) != 64'd0)      d.resp = RESP_SLVERR;
    else                                                          d.resp = RESP_OKAY;
    return d;
  endfunction

endpackage

// File: rtl/ram_array.sv
// Word storage: two synchronous read ports (data, fetch) and one byte-strobed write port.
module ram_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 1048576,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic                clk,
  input  logic                rd_en,
  input  logic [IW-1:0]       rd_idx,
  output logic [DATA_W-1:0]   rd_data,
  input  logic                fe_en,
  input  logic [IW-1:0]       fe_idx,
  output logic [DATA_W-1:0]   fe_data,
  input  logic                we,
  input  logic [IW-1:0]       wr_idx,
  input  logic [DATA_W/8-1:0] wr_strb,
  input  logic [DATA_W-1:0]   wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Non-blocking reads on the write edge return the pre-write word.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_idx];
    if (fe_en) fe_data <= mem[fe_idx];
    if (we)
      for (int i = 0; i < DATA_W/8; i++)
        if (wr_strb[i]) mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
  end

endmodule

// File: rtl/ram_axi.sv
// AXI-lite data RAM slave with registered fetch port.
// Define RAM_MTRACE_EN for a per-transaction simulation trace.
module ram_axi
  import ram_pkg::*;
#(
  parameter int               DATA_W    = 64,
  parameter int               ADDR_W    = 32,
  parameter int               DEPTH     = 1048576,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ADDR_W-1:0]   araddr_i,
  input  logic                arvalid_i,
  output logic                arready_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic [1:0]          rresp_o,
  output logic                rvalid_o,
  input  logic                rready_i,
  input  logic [ADDR_W-1:0]   awaddr_i,
  input  logic                awvalid_i,
  output logic                awready_o,
  input  logic [DATA_W-1:0]   wdata_i,
  input  logic [DATA_W/8-1:0] wstrb_i,
  input  logic                wvalid_i,
  output logic                wready_o,
  output logic [1:0]          bresp_o,
  output logic                bvalid_o,
  input  logic                bready_i,
  input  logic                inst_req_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [31:0]         inst_o,
  output logic                inst_valid_o,
  output logic                inst_err_o
);

  localparam int unsigned OFF_BITS = $clog2(DATA_W/8);
  localparam int          IW       = $clog2(DEPTH);
  localparam int          NLANE    = DATA_W/32;
  localparam int          LW       = (NLANE > 1) ? $clog2(NLANE) : 1;

  logic                rvalid_q, rvalid_d, rzero_q, rzero_d;
  logic [1:0]          rresp_q, rresp_d;
  logic                aw_held_q, aw_held_d, w_held_q, w_held_d;
  logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wstrb_q, wstrb_d;
  logic                bvalid_q, bvalid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                inst_valid_q, inst_valid_d, inst_err_q, inst_err_d, inst_zero_q, inst_zero_d;
  logic [LW-1:0]       lane_q, lane_d;

  dec_t              ar_dec, aw_dec, fe_dec;
  logic              ar_hs, commit, rd_en, fe_en, we;
  logic [DATA_W-1:0] arr_rd, arr_fe;
  logic              unused_dec;

  assign ar_dec = decode(64'(araddr_i),    64'(BASE_ADDR), 64'(DEPTH), OFF_BITS);
  assign aw_dec = decode(64'(awaddr_q),    64'(BASE_ADDR), 64'(DEPTH), OFF_BITS);
  assign fe_dec = decode(64'(inst_addr_i), 64'(BASE_ADDR), 64'(DEPTH), OFF_BITS);
  assign unused_dec = ^{ar_dec.idx[63:IW], aw_dec.idx[63:IW], fe_dec.idx[63:IW]};

  assign arready_o = !rvalid_q || rready_i;
  assign awready_o = !aw_held_q;
  assign wready_o  = !w_held_q;
  assign ar_hs     = arvalid_i && arready_o;
  assign commit    = aw_held_q && w_held_q && (!bvalid_q || bready_i);
  assign rd_en     = ar_hs && (ar_dec.resp == RESP_OKAY);
  assign fe_en     = inst_req_i && (fe_dec.resp != RESP_DECERR);
  // Gating with rst keeps a commit edge coincident with reset assertion from writing.
  assign we        = commit && (aw_dec.resp == RESP_OKAY) && rst;

  always_comb begin
    rvalid_d     = rvalid_q;
    rresp_d      = rresp_q;
    rzero_d      = rzero_q;
    aw_held_d    = aw_held_q;
    awaddr_d     = awaddr_q;
    w_held_d     = w_held_q;
    wdata_d      = wdata_q;
    wstrb_d      = wstrb_q;
    bvalid_d     = bvalid_q;
    bresp_d      = bresp_q;
    inst_valid_d = inst_req_i;
    inst_err_d   = inst_req_i && (fe_dec.resp == RESP_DECERR);
    inst_zero_d  = inst_zero_q;
    lane_d       = lane_q;
    if (ar_hs) begin
      rvalid_d = 1'b1;
      rresp_d  = ar_dec.resp;
      rzero_d  = (ar_dec.resp != RESP_OKAY);
    end else if (rready_i) begin
      rvalid_d = 1'b0;
    end
    if (commit) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      bresp_d   = aw_dec.resp;
    end else if (bready_i) begin
      bvalid_d = 1'b0;
    end
    if (awvalid_i && !aw_held_q) begin
      aw_held_d = 1'b1;
      awaddr_d  = awaddr_i;
    end
    if (wvalid_i && !w_held_q) begin
      w_held_d = 1'b1;
      wdata_d  = wdata_i;
      wstrb_d  = wstrb_i;
    end
    if (inst_req_i) begin
      inst_zero_d = (fe_dec.resp == RESP_DECERR);
      lane_d      = LW'((inst_addr_i >> 2) & ADDR_W'(NLANE-1));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rvalid_q <= 1'b0; rresp_q <= '0; rzero_q <= 1'b1;
      aw_held_q <= 1'b0; awaddr_q <= '0;
      w_held_q <= 1'b0; wdata_q <= '0; wstrb_q <= '0;
      bvalid_q <= 1'b0; bresp_q <= '0;
      inst_valid_q <= 1'b0; inst_err_q <= 1'b0; inst_zero_q <= 1'b1; lane_q <= '0;
    end else begin
      rvalid_q <= rvalid_d; rresp_q <= rresp_d; rzero_q <= rzero_d;
      aw_held_q <= aw_held_d; awaddr_q <= awaddr_d;
      w_held_q <= w_held_d; wdata_q <= wdata_d; wstrb_q <= wstrb_d;
      bvalid_q <= bvalid_d; bresp_q <= bresp_d;
      inst_valid_q <= inst_valid_d; inst_err_q <= inst_err_d; inst_zero_q <= inst_zero_d;
      lane_q <= lane_d;
    end
  end

  ram_array #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_array (
    .clk     (clk),
    .rd_en   (rd_en),
    .rd_idx  (ar_dec.idx[IW-1:0]),
    .rd_data (arr_rd),
    .fe_en   (fe_en),
    .fe_idx  (fe_dec.idx[IW-1:0]),
    .fe_data (arr_fe),
    .we      (we),
    .wr_idx  (aw_dec.idx[IW-1:0]),
    .wr_strb (wstrb_q),
    .wr_data (wdata_q)
  );

  // Zero flags mask stale array output after reset and on error responses.
  assign rdata_o      = rzero_q ? '0 : arr_rd;
  assign rresp_o      = rresp_q;
  assign rvalid_o     = rvalid_q;
  assign bresp_o      = bresp_q;
  assign bvalid_o     = bvalid_q;
  assign inst_o       = inst_zero_q ? 32'd0 : arr_fe[lane_q*32 +: 32];
  assign inst_valid_o = inst_valid_q;
  assign inst_err_o   = inst_err_q;

`ifdef RAM_MTRACE_EN
  logic [ADDR_W-1:0] raddr_q;
  always @(posedge clk) begin
    if (ar_hs) raddr_q <= araddr_i;
    if (rst) begin
      if (rvalid_o && rready_i) begin
        $display("[ram] read  addr=%h data=%h resp=%b", raddr_q, rdata_o, rresp_o);
        if (rresp_o != RESP_OKAY) $display("[ram] warning: read resp %b at %h", rresp_o, raddr_q);
      end
      if (commit) begin
        $display("[ram] write addr=%h strb=%h data=%h resp=%b", awaddr_q, wstrb_q, wdata_q, aw_dec.resp);
        if (aw_dec.resp != RESP_OKAY) $display("[ram] warning: write resp %b at %h", aw_dec.resp, awaddr_q);
      end
      if (inst_req_i) begin
        $display("[ram] fetch addr=%h", inst_addr_i);
        if (fe_dec.resp == RESP_DECERR) $display("[ram] warning: fetch out of range at %h", inst_addr_i);
      end
    end
  end
`endif

endmodule

// File: tb/tb_ram_axi.sv
// Directed scoreboard bench for ram_axi.
module tb_ram_axi;

  localparam logic [1:0] OK = 2'b00, SLV = 2'b10, DEC = 2'b11;

  logic        clk, rst;
  logic [31:0] araddr, awaddr, inst_addr;
  logic        arvalid, arready, rvalid, rready;
  logic [63:0] rdata, wdata;
  logic [1:0]  rresp, bresp;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic [7:0]  wstrb;
  logic        inst_req, inst_valid, inst_err;
  logic [31:0] inst;

  typedef struct { logic [63:0] d; logic [1:0] r; } rexp_t;
  rexp_t      rq[$];
  logic [1:0] bq[$];
  int total = 0, bad = 0;

  ram_axi dut (
    .clk(clk), .rst(rst),
    .araddr_i(araddr), .arvalid_i(arvalid), .arready_o(arready),
    .rdata_o(rdata), .rresp_o(rresp), .rvalid_o(rvalid), .rready_i(rready),
    .awaddr_i(awaddr), .awvalid_i(awvalid), .awready_o(awready),
    .wdata_i(wdata), .wstrb_i(wstrb), .wvalid_i(wvalid), .wready_o(wready),
    .bresp_o(bresp), .bvalid_o(bvalid), .bready_i(bready),
    .inst_req_i(inst_req), .inst_addr_i(inst_addr), .inst_o(inst),
    .inst_valid_o(inst_valid), .inst_err_o(inst_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_r(input string tag);
    rexp_t e;
    chk({tag, "_rvalid"}, rvalid, 1);
    if (rq.size() == 0) begin chk({tag, "_rq_empty"}, 1, 0); return; end
    e = rq.pop_front();
    chk({tag, "_rdata"}, rdata, e.d);
    chk({tag, "_rresp"}, rresp, e.r);
  endtask

  task automatic check_b(input string tag);
    chk({tag, "_bvalid"}, bvalid, 1);
    if (bq.size() == 0) begin chk({tag, "_bq_empty"}, 1, 0); return; end
    chk({tag, "_bresp"}, bresp, bq.pop_front());
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [63:0] d,
                          input logic [7:0] s, input logic [1:0] er);
    int n;
    awaddr = a; awvalid = 1; wdata = d; wstrb = s; wvalid = 1; bready = 0;
    bq.push_back(er);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    n = 1;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk({tag, "_blat"}, 64'(n), 64'd2);
    check_b(tag);
    bready = 1;
    @(negedge clk);
    bready = 0;
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, input logic [63:0] d,
                         input logic [1:0] er);
    araddr = a; arvalid = 1; rready = 1;
    rq.push_back('{d, er});
    @(negedge clk);
    arvalid = 0;
    check_r(tag);
  endtask

  initial begin
    logic [31:0] ca[4];
    logic [63:0] ce[4];
    rst = 0; araddr = 0; arvalid = 0; rready = 0; awaddr = 0; awvalid = 0;
    wdata = 0; wstrb = 0; wvalid = 0; bready = 0; inst_req = 0; inst_addr = 0;
    repeat (2) @(negedge clk);
    chk("rst_arready", arready, 1);
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_ivalid", inst_valid, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_inst", inst, 0);
    rst = 1;
    @(negedge clk);

    do_write("wr_full", 32'h8000_0008, 64'h1122334455667788, 8'hFF, OK);
    do_read("rd_full", 32'h8000_0008, 64'h1122334455667788, OK);
    do_write("wr_part", 32'h8000_0008, 64'hAAAAAAAABBBBBBBB, 8'h0F, OK);
    do_read("rd_part", 32'h8000_0008, 64'h11223344BBBBBBBB, OK);

    inst_req = 1; inst_addr = 32'h8000_000C;
    @(negedge clk);
    inst_req = 0;
    chk("fe_valid", inst_valid, 1);
    chk("fe_inst", inst, 32'h11223344);
    chk("fe_err", inst_err, 0);
    inst_req = 1; inst_addr = 32'h0000_0000;
    @(negedge clk);
    inst_req = 0;
    chk("fe_oor_valid", inst_valid, 1);
    chk("fe_oor_err", inst_err, 1);
    chk("fe_oor_inst", inst, 0);
    @(negedge clk);
    chk("fe_idle", inst_valid, 0);

    do_read("rd_below", 32'h7FFF_FFF8, 64'd0, DEC);
    do_write("wr_w0", 32'h8000_0000, 64'hCAFE0000_0000BEEF, 8'hFF, OK);
    do_write("wr_slv", 32'h8000_0004, 64'hFFFFFFFF_FFFFFFFF, 8'hFF, SLV);
    do_read("rd_w0", 32'h8000_0000, 64'hCAFE0000_0000BEEF, OK);
    do_read("rd_slv", 32'h8000_000C, 64'd0, SLV);
    do_read("rd_above", 32'h8080_0000, 64'd0, DEC);
    do_write("wr_last", 32'h807F_FFF8, 64'h5A5A5A5A_A5A5A5A5, 8'hFF, OK);
    do_read("rd_last", 32'h807F_FFF8, 64'h5A5A5A5A_A5A5A5A5, OK);

    // W leads AW by three cycles; a second pair then waits behind a stalled B.
    wdata = 64'h0123456789ABCDEF; wstrb = 8'hFF; wvalid = 1; bready = 0;
    @(negedge clk);
    wvalid = 0;
    chk("early_wready", wready, 0);
    chk("early_awready", awready, 1);
    repeat (2) @(negedge clk);
    awaddr = 32'h8000_0010; awvalid = 1; bq.push_back(OK);
    @(negedge clk);
    awvalid = 0;
    chk("both_awready", awready, 0);
    chk("both_wready", wready, 0);
    @(negedge clk);
    check_b("early_b");
    awaddr = 32'h8000_0018; awvalid = 1; wdata = 64'hDEADBEEF_01020304; wvalid = 1;
    bq.push_back(OK);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_bvalid", bvalid, 1);
      chk("stall_awready", awready, 0);
      chk("stall_wready", wready, 0);
      @(negedge clk);
    end
    bready = 1;
    @(negedge clk);
    check_b("second_b");
    @(negedge clk);
    chk("b_drained", bvalid, 0);
    bready = 0;
    @(negedge clk);
    chk("no_extra_b", bvalid, 0);
    do_read("rd_early", 32'h8000_0010, 64'h0123456789ABCDEF, OK);
    do_read("rd_second", 32'h8000_0018, 64'hDEADBEEF_01020304, OK);

    // Read sampling the word on its commit edge sees the old value.
    do_write("wr_old", 32'h8000_0020, 64'hA0A0A0A0_A0A0A0A0, 8'hFF, OK);
    awaddr = 32'h8000_0020; wdata = 64'hB1B1B1B1_B1B1B1B1; wstrb = 8'hFF;
    awvalid = 1; wvalid = 1; bq.push_back(OK);
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    araddr = 32'h8000_0020; arvalid = 1; rready = 1;
    rq.push_back('{64'hA0A0A0A0_A0A0A0A0, OK});
    @(negedge clk);
    arvalid = 0;
    check_r("coll_old");
    check_b("coll_b");
    bready = 1;
    @(negedge clk);
    bready = 0;
    do_read("coll_new", 32'h8000_0020, 64'hB1B1B1B1_B1B1B1B1, OK);

    ca[0] = 32'h8000_0008; ce[0] = 64'h11223344BBBBBBBB;
    ca[1] = 32'h8000_0010; ce[1] = 64'h0123456789ABCDEF;
    ca[2] = 32'h8000_0018; ce[2] = 64'hDEADBEEF_01020304;
    ca[3] = 32'h8000_0020; ce[3] = 64'hB1B1B1B1_B1B1B1B1;
    arvalid = 1; rready = 1;
    for (int i = 0; i < 4; i++) begin
      araddr = ca[i];
      rq.push_back('{ce[i], OK});
      @(negedge clk);
      check_r("burst");
    end
    arvalid = 0;
    @(negedge clk);
    chk("burst_end", rvalid, 0);

    rready = 0; araddr = 32'h8000_0010; arvalid = 1;
    rq.push_back('{64'h0123456789ABCDEF, OK});
    @(negedge clk);
    arvalid = 0;
    chk("bp_arready", arready, 0);
    @(negedge clk);
    check_r("bp_hold");
    rready = 1;
    @(negedge clk);
    chk("bp_done", rvalid, 0);

    awaddr = 32'h8000_0028; wdata = 64'h7; wstrb = 8'hFF; awvalid = 1; wvalid = 1;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    @(negedge clk);
    chk("pre_rst_bvalid", bvalid, 1);
    #2 rst = 0;
    #1;
    chk("async_bvalid", bvalid, 0);
    chk("async_bresp", bresp, 0);
    chk("async_awready", awready, 1);
    @(negedge clk);
    rst = 1;
    @(negedge clk);
    chk("post_rst_bvalid", bvalid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_axi.md
# ram_axi

Parametrised single-clock data RAM slave replacing the combinational-read RAM. It exposes AXI-lite style valid/ready channels (AR, R, AW, W, B) with byte strobes, response codes and address decode, plus a registered 32-bit instruction-fetch port. It sits between the core's AXI bridge and the fetch stage, and is the behavioural main memory for simulation.

## Interface

- DATA_W, 64: data width in bits; power of two, at least 32.
- ADDR_W, 32: address width.
- DEPTH, 1048576: number of DATA_W-bit words.
- BASE_ADDR, 32'h8000_0000: byte address of word 0.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- araddr_i  in  ADDR_W  read address.
- arvalid_i  in  1  read address valid.
- arready_o  out  1  read address accepted.
- rdata_o  out  DATA_W  read data.
- rresp_o  out  2  read response.
- rvalid_o  out  1  read data valid.
- rready_i  in  1  read data consumed.
- awaddr_i  in  ADDR_W  write address.
- awvalid_i / awready_o  in / out  1 each  write address handshake.
- wdata_i  in  DATA_W  write data.
- wstrb_i  in  DATA_W/8  byte enables; 1 = write that byte.
- wvalid_i / wready_o  in / out  1 each  write data handshake.
- bresp_o  out  2  write response.
- bvalid_o / bready_i  out / in  1 each  write response handshake.
- inst_req_i  in  1  fetch request.
- inst_addr_i  in  ADDR_W  fetch byte address; 4-byte aligned.
- inst_o  out  32  fetched instruction.
- inst_valid_o  out  1  inst_o valid this cycle.
- inst_err_o  out  1  fetch address out of range.

## Operation

- Decode: idx = (addr - BASE_ADDR) >> log2(DATA_W/8).
  - DECERR (2'b11): addr < BASE_ADDR or idx >= DEPTH.
  - SLVERR (2'b10): in range but the low log2(DATA_W/8) bits are non-zero.
  - OKAY (2'b00): otherwise.
  - Error reads return rdata 0. Error writes modify nothing.
- Read channel: arready_o = !rvalid_o || rready_i.
  - A handshake at edge T latches the array word, response code and rvalid_o=1 at T+1.
  - rdata_o/rresp_o hold stable until the rready_i handshake.
  - Back-to-back reads sustain one per cycle.
- Write channel: AW and W are accepted independently into holding registers. awready_o = !aw_held; wready_o = !w_held.
  - Commit happens on the edge where aw_held && w_held && (!bvalid_o || bready_i).
  - Commit: byte i of the word is written iff wstrb_i[i], using the held strobe. Holds are cleared. bvalid_o=1 and bresp_o is set.
  - bvalid_o holds until bready_i. Only one outstanding B.
- Fetch: when inst_req_i is high at edge T, at T+1 inst_valid_o=1 and inst_o = the 32-bit lane of the word selected by inst_addr_i bits.
  - Out-of-range fetch gives inst_o=0, inst_err_o=1.
  - inst_valid_o=0 when there is no request.
- Collisions: a read or fetch sampling a word on the same edge as a commit to that word returns the pre-write data. Reads and writes never stall each other.
- Array contents are not reset.

## Timing

- Reset (rst low, asynchronous) clears:
  - rvalid_o, bvalid_o, inst_valid_o, inst_err_o.
  - aw_held, w_held.
  - rdata_o, inst_o, rresp_o, bresp_o (all to 0).
  - Consequently arready_o, awready_o and wready_o read 1 while in reset.
- Reset mid-transaction drops any pending R or B and any held AW/W without writing. A commit edge coincident with reset assertion does not write.
- Latencies:
  - AR handshake to rvalid_o: 1 cycle.
  - AW and W in the same cycle to bvalid_o: 2 cycles.
  - Fetch: 1 cycle.

## Configuration

- RAM_MTRACE_EN defined: $display one line per accepted read (addr, data, resp), per commit (addr, strb, data, resp) and per fetch, plus a warning on every non-OKAY response.
- Undefined: no simulation output; behaviour is otherwise identical.

## Structure

- Package ram_pkg holds:
  - Response constants RESP_OKAY, RESP_SLVERR, RESP_DECERR.
  - A decode function returning {resp, idx}.
- Sub-module ram_array holds the storage:
  - one synchronous read port;
  - one synchronous fetch read port;
  - one byte-strobed synchronous write port.
- ram_axi contains the handshake logic, holding registers and decode.

## Test plan

- Reset, then AW 0x8000_0008 / W 0x1122334455667788 with strobe 0xFF in the same cycle -> bvalid at +2 with OKAY; then read 0x8000_0008 -> rdata 0x1122334455667788, OKAY, at +1.
- Partial write strobe 0x0F, data 0xAAAAAAAABBBBBBBB over the prior value -> readback 0x11223344BBBBBBBB.
- W presented 3 cycles before AW, with bready held low 4 cycles -> single commit; awready/wready stay low while both holds are full; no second B.
- Read 0x7FFF_FFF8 -> DECERR, rdata 0; write 0x8000_0004 -> SLVERR, memory unchanged.
- Commit and read of the same word on the same edge -> old data returned; next read returns new data. Continuous arvalid with rready=1 -> one rvalid per cycle.
- Fetch 0x8000_000C after the first test -> inst_o 0x11223344 at +1, inst_valid_o=1. rst pulsed low while bvalid is pending -> bvalid drops immediately.
